// File: rtl/rpn_pkg.sv
// Shared key-id codes, FSM states and key decoding helpers for the RPN calculator sequencer.
package rpn_pkg;

    localparam logic [3:0] KEY_0   = 4'b0011;
    localparam logic [3:0] KEY_1   = 4'b0000;
    localparam logic [3:0] KEY_2   = 4'b0100;
    localparam logic [3:0] KEY_3   = 4'b1000;
    localparam logic [3:0] KEY_4   = 4'b0001;
    localparam logic [3:0] KEY_5   = 4'b0101;
    localparam logic [3:0] KEY_6   = 4'b1001;
    localparam logic [3:0] KEY_7   = 4'b0010;
    localparam logic [3:0] KEY_8   = 4'b0110;
    localparam logic [3:0] KEY_9   = 4'b1010;
    localparam logic [3:0] KEY_EQ  = 4'b1100;
    localparam logic [3:0] KEY_ADD = 4'b1101;
    localparam logic [3:0] KEY_SUB = 4'b1110;
    localparam logic [3:0] KEY_MUL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        RELEASE
    } state_t;

    function automatic logic is_digit(input logic [3:0] id);
        logic result;
        case (id)
            KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
            KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: result = 1'b1;
            default:                           result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic is_command(input logic [3:0] id);
        return (id[3:2] == 2'b11);
    endfunction

    function automatic logic [3:0] digit_value(input logic [3:0] id);
        logic [3:0] result;
        case (id)
            KEY_0:   result = 4'd0;
            KEY_1:   result = 4'd1;
            KEY_2:   result = 4'd2;
            KEY_3:   result = 4'd3;
            KEY_4:   result = 4'd4;
            KEY_5:   result = 4'd5;
            KEY_6:   result = 4'd6;
            KEY_7:   result = 4'd7;
            KEY_8:   result = 4'd8;
            KEY_9:   result = 4'd9;
            default: result = 4'd0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/rpn_shift_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, LSB first, low WIDTH bits kept.
module rpn_shift_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_step;
    logic [CW-1:0]    remaining;

    // The final product is presented combinationally during the last iteration,
    // so the caller can register it without an extra cycle.
    assign acc_step = multiplier[0] ? (acc + multiplicand) : acc;
    assign done     = (remaining == CW'(1));
    assign product  = acc_step;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            multiplicand <= '0;
            multiplier   <= '0;
            acc          <= '0;
            remaining    <= '0;
        end else if (start) begin
            multiplicand <= a;
            multiplier   <= b;
            acc          <= '0;
            remaining    <= CW'(WIDTH);
        end else if (remaining != '0) begin
            acc          <= acc_step;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            remaining    <= remaining - CW'(1);
        end
    end

endmodule

// File: rtl/rpn_sequencer.sv
// Turns each fresh numpad press into exactly one guarded stack transaction
// (push / pop / write pulses plus write data) for the RPN operand stack.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       key,
    input  logic [WIDTH-1:0] top,
    input  logic [WIDTH-1:0] next,
    input  logic [5:0]       count,
    output logic             push,
    output logic             pop,
    output logic             write,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             error
);
    state_t           state, state_next;
    logic             prev_valid;
    logic             press;
    logic [3:0]       key_id;
    logic [WIDTH-1:0] top_q, next_q;
    logic [5:0]       count_q;
    logic             push_d, pop_d, write_d, error_d;
    logic [WIDTH-1:0] value_d;
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH+3:0] digit_sum;
    logic             digit_overflow;
    logic             operands_short;

    // Rising edge of key-valid only; unused ids never leave IDLE.
    assign press = (state == IDLE) && key[4] && !prev_valid &&
                   (is_digit(key[3:0]) || is_command(key[3:0]));

    assign digit_sum      = ({4'b0000, top_q} << 3) + ({4'b0000, top_q} << 1) +
                            {{WIDTH{1'b0}}, digit_value(key_id)};
    assign digit_overflow = |digit_sum[WIDTH+3:WIDTH];
    assign operands_short = (count_q < 6'd2);
    assign busy           = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press) state_next = EXEC;
            EXEC:    state_next = (key_id == KEY_MUL && !operands_short) ? MUL : RELEASE;
            MUL:     if (mul_done) state_next = RELEASE;
            RELEASE: if (!key[4]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push_d    = 1'b0;
        pop_d     = 1'b0;
        write_d   = 1'b0;
        value_d   = value;
        error_d   = error;
        mul_start = 1'b0;
        case (state)
            EXEC: begin
                if (is_digit(key_id)) begin
                    if (digit_overflow) begin
                        error_d = 1'b1;
                    end else begin
                        write_d = 1'b1;
                        value_d = digit_sum[WIDTH-1:0];
                        error_d = 1'b0;
                    end
                end else begin
                    case (key_id)
                        KEY_EQ: begin
                            if (count_q == 6'(DEPTH)) error_d = 1'b1;
                            else                      push_d  = 1'b1;
                        end
                        KEY_ADD, KEY_SUB: begin
                            if (operands_short) begin
                                error_d = 1'b1;
                            end else begin
                                pop_d   = 1'b1;
                                write_d = 1'b1;
                                value_d = (key_id == KEY_ADD) ? (next_q + top_q) : (next_q - top_q);
                            end
                        end
                        KEY_MUL: begin
                            if (operands_short) error_d   = 1'b1;
                            else                mul_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (mul_done) begin
                    pop_d   = 1'b1;
                    write_d = 1'b1;
                    value_d = mul_product;
                end
            end
            default: ;
        endcase
    end

    // Operands are snapshotted at the press so stack changes cannot disturb a command in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_valid <= 1'b0;
            key_id     <= '0;
            top_q      <= '0;
            next_q     <= '0;
            count_q    <= '0;
        end else begin
            prev_valid <= key[4];
            if (press) begin
                key_id  <= key[3:0];
                top_q   <= top;
                next_q  <= next;
                count_q <= count;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            push  <= 1'b0;
            pop   <= 1'b0;
            write <= 1'b0;
            value <= '0;
            error <= 1'b0;
        end else begin
            push  <= push_d;
            pop   <= pop_d;
            write <= write_d;
            value <= value_d;
            error <= error_d;
        end
    end

    rpn_shift_mul #(
        .WIDTH(WIDTH)
    ) u_shift_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (next_q),
        .b       (top_q),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_rpn_sequencer.sv
// Scoreboard bench for rpn_sequencer: expected stack transactions are queued at each press
// and matched against the pulses the sequencer emits.
module tb_rpn_sequencer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;

    localparam logic [3:0] K_EQ  = 4'b1100;
    localparam logic [3:0] K_ADD = 4'b1101;
    localparam logic [3:0] K_SUB = 4'b1110;
    localparam logic [3:0] K_MUL = 4'b1111;

    typedef struct {
        int               cycle;
        logic             push;
        logic             pop;
        logic             write;
        logic [WIDTH-1:0] value;
    } expect_t;

    logic             clock;
    logic             reset;
    logic [4:0]       key;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [5:0]       count;
    logic             push, pop, write, busy, error;
    logic [WIDTH-1:0] value;

    expect_t    expect_q[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic       exp_error = 1'b0;
    logic [3:0] key_of [10] = '{4'b0011, 4'b0000, 4'b0100, 4'b1000, 4'b0001,
                                4'b0101, 4'b1001, 4'b0010, 4'b0110, 4'b1010};

    rpn_sequencer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .key   (key),
        .top   (top),
        .next  (next),
        .count (count),
        .push  (push),
        .pop   (pop),
        .write (write),
        .value (value),
        .busy  (busy),
        .error (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Any pulse must match the head of the queue in kind, data and cycle.
    always @(negedge clock) begin
        expect_t e;
        if (!reset) begin
            if (expect_q.size() > 0 && cyc > expect_q[0].cycle) begin
                checkOutput("missing_pulse", 64'(0), 64'(1));
                void'(expect_q.pop_front());
            end
            if (push || pop || write) begin
                if (expect_q.size() == 0) begin
                    checkOutput("unexpected_pulse", 64'({push, pop, write}), 64'(0));
                end else begin
                    e = expect_q.pop_front();
                    checkOutput("pulse_cycle", 64'(cyc), 64'(e.cycle));
                    checkOutput("pulse_kind", 64'({push, pop, write}), 64'({e.push, e.pop, e.write}));
                    if (e.write) checkOutput("value", 64'(value), 64'(e.value));
                end
            end
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("idle_timeout", 64'(busy), 64'(0));
        repeat (2) @(negedge clock);
    endtask

    task automatic setStack(input int n, input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] nx);
        @(posedge clock);
        #1;
        count = 6'(n);
        top   = t;
        next  = nx;
    endtask

    task automatic applyStimulus(input logic [3:0] id, input int hold, input bit swap);
        int         d;
        int         start;
        bit         pulse;
        logic [63:0] wide;
        expect_t    e;
        d       = -1;
        pulse   = 1'b0;
        e.push  = 1'b0;
        e.pop   = 1'b0;
        e.write = 1'b0;
        e.value = '0;
        for (int i = 0; i < 10; i++) if (key_of[i] == id) d = i;
        @(posedge clock);
        #1;
        start   = cyc;
        e.cycle = start + 2;
        if (d >= 0) begin
            wide = 64'(top) * 64'd10 + 64'(d);
            if (wide > 64'hFFFF_FFFF) exp_error = 1'b1;
            else begin
                pulse = 1'b1; e.write = 1'b1; e.value = wide[WIDTH-1:0]; exp_error = 1'b0;
            end
        end else if (id == K_EQ) begin
            if (count == 6'(DEPTH)) exp_error = 1'b1;
            else begin pulse = 1'b1; e.push = 1'b1; end
        end else if (id == K_ADD || id == K_SUB) begin
            if (count < 6'd2) exp_error = 1'b1;
            else begin
                pulse = 1'b1; e.pop = 1'b1; e.write = 1'b1;
                e.value = (id == K_ADD) ? next + top : next - top;
            end
        end else if (id == K_MUL) begin
            if (count < 6'd2) exp_error = 1'b1;
            else begin
                pulse = 1'b1; e.pop = 1'b1; e.write = 1'b1;
                e.value = WIDTH'(64'(next) * 64'(top));
                e.cycle = start + WIDTH + 2;
            end
        end
        if (pulse) expect_q.push_back(e);
        key = {1'b1, id};
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            if (swap && i == hold / 2) key[3:0] = K_MUL;
        end
        key = 5'b0;
        waitIdle();
        if (pulse) begin
            if (e.push) begin
                next  = top;
                count = count + 6'd1;
            end else if (e.pop) begin
                top   = e.value;
                next  = '0;
                count = count - 6'd1;
            end else begin
                top = e.value;
            end
        end
        checkOutput("error", 64'(error), 64'(exp_error));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        key   = 5'b0;
        top   = '0;
        next  = '0;
        count = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_pulses", 64'({push, pop, write}), 64'(0));
        checkOutput("reset_value", 64'(value), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_error", 64'(error), 64'(0));
        reset = 1'b0;
        repeat (2) @(posedge clock);

        $display("[TB] digit entry 1, 2");
        setStack(1, 0, 0);
        applyStimulus(key_of[1], 1, 1'b0);
        applyStimulus(key_of[2], 1, 1'b0);

        $display("[TB] held key 5 with code change");
        applyStimulus(key_of[5], 20, 1'b1);

        $display("[TB] subtract / add");
        setStack(2, 7, 5);
        applyStimulus(K_SUB, 1, 1'b0);
        setStack(2, 7, 5);
        applyStimulus(K_ADD, 1, 1'b0);

        $display("[TB] multiply");
        setStack(2, 6, 7);
        applyStimulus(K_MUL, 2, 1'b0);
        setStack(2, 32'hFFFF_FFFF, 2);
        applyStimulus(K_MUL, 2, 1'b0);

        $display("[TB] underflow / overflow guards");
        setStack(1, 5, 0);
        applyStimulus(K_ADD, 1, 1'b0);
        applyStimulus(key_of[3], 1, 1'b0);
        setStack(DEPTH, 1, 1);
        applyStimulus(K_EQ, 1, 1'b0);
        setStack(3, 9, 1);
        applyStimulus(K_EQ, 1, 1'b0);
        setStack(1, 4, 0);
        applyStimulus(K_MUL, 1, 1'b0);

        $display("[TB] digit-entry overflow boundary");
        setStack(1, 429496729, 0);
        applyStimulus(key_of[6], 1, 1'b0);
        setStack(1, 429496729, 0);
        applyStimulus(key_of[5], 1, 1'b0);

        $display("[TB] random digit entry");
        for (int i = 0; i < 4; i++) begin
            setStack(1, $urandom_range(0, 100000), 0);
            applyStimulus(key_of[$urandom_range(0, 9)], $urandom_range(1, 3), 1'b0);
        end

        $display("[TB] reset during multiply");
        setStack(2, 6, 7);
        @(posedge clock);
        #1;
        key = {1'b1, K_MUL};
        repeat (5) @(posedge clock);
        #1;
        checkOutput("busy_in_mul", 64'(busy), 64'(1));
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_pulses", 64'({push, pop, write}), 64'(0));
        checkOutput("abort_value", 64'(value), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_error", 64'(error), 64'(0));
        key = 5'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (WIDTH + 10) @(posedge clock);
        #1;
        checkOutput("busy_after_abort", 64'(busy), 64'(0));
        checkOutput("queue_empty", 64'(expect_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
